// File: rtl/ms_apb_pkg.sv
// Shared definitions for the APB master: FSM state encoding and the default
// ACCESS-phase timeout.
package ms_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam logic [15:0] DEFAULT_TIMEOUT = 16'd256;

endpackage

// File: rtl/ms_apb_master.sv
// Single-outstanding APB master: takes one command, runs SETUP/ACCESS on the
// bus, and holds a response until it is consumed. Optional ACCESS timeout.
module ms_apb_master
    import ms_apb_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        PCLK,
    input  logic        PRESET,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,

    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,

    output logic        busy
);

    apb_state_e  state;
    logic [15:0] wait_count;
    logic [15:0] count_next;

    // The timeout fires in the ACCESS cycle whose increment would reach
    // TIMEOUT, so the ACCESS phase lasts exactly TIMEOUT cycles.
    assign count_next = wait_count + 16'd1;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= ST_IDLE;
            wait_count  <= 16'd0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= 32'd0;
            PWDATA      <= 32'd0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        PWRITE  <= cmd_write;
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_wdata;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE    <= 1'b1;
                    wait_count <= 16'd0;
                    state      <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // PREADY is checked first so a ready slave beats the timeout.
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? 32'd0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        state       <= ST_RESP;
                    end else if ((TIMEOUT != 16'd0) && (count_next == TIMEOUT)) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= 32'd0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        wait_count  <= count_next;
                        state       <= ST_RESP;
                    end else begin
                        wait_count <= count_next;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms_apb_master.sv
// Table-driven bench for ms_apb_master: each vector runs one APB transfer
// with a scripted slave; responses are checked through a scoreboard queue.
module tb_ms_apb_master;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
        logic        stall;
        logic        slverr;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_acc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = 32'd0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;
    logic        busy;

    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];
    vec_t vecs[7];

    ms_apb_master #(.TIMEOUT(16'd4)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge PCLK);
        #1;
    endtask

    // Drives one command, plays the slave for the vector, then holds and drains the response.
    task automatic applyStimulus(input vec_t v);
        int   acc;
        bit   done;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        @(negedge PCLK);
        checkOutput("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        sbq.push_back('{v.exp_rdata, v.exp_err, v.exp_to});
        nextCycle();
        cmd_valid = 1'b0;
        cmd_write = ~v.write;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        @(negedge PCLK);
        checkOutput("setup_psel", {31'd0, PSEL}, 32'd1);
        checkOutput("setup_penable", {31'd0, PENABLE}, 32'd0);
        checkOutput("setup_paddr", PADDR, v.addr);
        checkOutput("setup_pwrite", {31'd0, PWRITE}, {31'd0, v.write});
        checkOutput("setup_pwdata", PWDATA, v.wdata);
        checkOutput("setup_busy", {31'd0, busy}, 32'd1);
        nextCycle();
        acc  = 0;
        done = 1'b0;
        while (!done && acc < 40) begin
            PREADY  = !v.stall && (acc == v.waits);
            PRDATA  = v.prdata;
            PSLVERR = v.slverr;
            @(negedge PCLK);
            checkOutput("access_psel", {31'd0, PSEL}, 32'd1);
            checkOutput("access_penable", {31'd0, PENABLE}, 32'd1);
            checkOutput("access_paddr", PADDR, v.addr);
            checkOutput("access_pwdata", PWDATA, v.wdata);
            checkOutput("access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            acc++;
            nextCycle();
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = $urandom;
            if (rsp_valid) done = 1'b1;
        end
        checkOutput("rsp_within_bound", {31'd0, done}, 32'd1);
        checkOutput("access_cycles", acc, v.exp_acc);
        // Response must hold while not consumed; a pending command must be ignored.
        for (int h = 0; h < v.hold; h++) begin
            cmd_valid = 1'b1;
            @(negedge PCLK);
            checkOutput("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("hold_rdata", rsp_rdata, sbq[0].rdata);
            checkOutput("hold_err", {31'd0, rsp_err}, {31'd0, sbq[0].err});
            checkOutput("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            checkOutput("hold_psel", {31'd0, PSEL}, 32'd0);
            nextCycle();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge PCLK);
        checkOutput("resp_psel", {31'd0, PSEL}, 32'd0);
        checkOutput("resp_penable", {31'd0, PENABLE}, 32'd0);
        if (sbq.size() == 0) begin
            checkOutput("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            checkOutput("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("rsp_rdata", rsp_rdata, e.rdata);
            checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            checkOutput("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
        end
        nextCycle();
        rsp_ready = 1'b0;
        @(negedge PCLK);
        checkOutput("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("post_busy", {31'd0, busy}, 32'd0);
        nextCycle();
    endtask

    initial begin
        //          wr    addr          wdata         prdata        wt stall err hold  exp_rdata     err   to    acc
        vecs[0] = '{1'b1, 32'h0000_0004, 32'h0000_1234, 32'h0000_0000, 0, 1'b0, 1'b0, 0, 32'h0000_0000, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 32'h0000_0200, 32'h1111_1111, 32'h0000_002A, 3, 1'b0, 1'b0, 0, 32'h0000_002A, 1'b0, 1'b0, 4};
        vecs[2] = '{1'b0, 32'h0000_0300, 32'h0000_0000, 32'hDEAD_BEEF, 0, 1'b1, 1'b0, 0, 32'h0000_0000, 1'b1, 1'b1, 4};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0055, 0, 1'b0, 1'b1, 0, 32'h0000_0055, 1'b1, 1'b0, 1};
        vecs[4] = '{1'b0, 32'h0000_0044, 32'h2222_2222, 32'hCAFE_F00D, 1, 1'b0, 1'b0, 5, 32'hCAFE_F00D, 1'b0, 1'b0, 2};
        vecs[5] = '{1'b1, 32'h8000_0008, 32'hA5A5_5A5A, 32'h1234_5678, 2, 1'b0, 1'b1, 1, 32'h0000_0000, 1'b1, 1'b0, 3};
        vecs[6] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h7777_7777, 0, 1'b0, 1'b0, 2, 32'h0000_0000, 1'b0, 1'b0, 1};

        repeat (2) @(posedge PCLK);
        #1;
        @(negedge PCLK);
        checkOutput("reset_psel", {31'd0, PSEL}, 32'd0);
        checkOutput("reset_penable", {31'd0, PENABLE}, 32'd0);
        checkOutput("reset_paddr", PADDR, 32'd0);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        nextCycle();
        PRESET = 1'b0;
        nextCycle();

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Reset during ACCESS must drop PSEL/PENABLE asynchronously and emit no response.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0ABC;
        nextCycle();
        cmd_valid = 1'b0;
        nextCycle();
        nextCycle();
        @(negedge PCLK);
        checkOutput("pre_reset_penable", {31'd0, PENABLE}, 32'd1);
        #2;
        PRESET = 1'b1;
        #1;
        checkOutput("async_reset_psel", {31'd0, PSEL}, 32'd0);
        checkOutput("async_reset_penable", {31'd0, PENABLE}, 32'd0);
        checkOutput("async_reset_paddr", PADDR, 32'd0);
        nextCycle();
        PRESET = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge PCLK);
            checkOutput("after_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            checkOutput("after_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
            nextCycle();
        end
        applyStimulus(vecs[1]);
        applyStimulus(vecs[0]);

        checkOutput("scoreboard_drained", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ms_apb_master.md
MS_APB_MASTER -- requirements
Module: ms_apb_master

Interface
REQ-001 Parameter: TIMEOUT, 16'd256, ACCESS-phase cycle limit before abort; 0 disables the timeout.
REQ-002 Port: PCLK  input  1  sole clock, rising edge.
REQ-003 Port: PRESET  input  1  asynchronous, active-high reset.
REQ-004 Port: cmd_valid  input  1  command request.
REQ-005 Port: cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-006 Port: cmd_write  input  1  1 = write, 0 = read.
REQ-007 Port: cmd_addr  input  32  transfer address.
REQ-008 Port: cmd_wdata  input  32  write data.
REQ-009 Port: rsp_valid  output  1  response available.
REQ-010 Port: rsp_ready  input  1  response consumed.
REQ-011 Port: rsp_rdata  output  32  read data; 0 for writes and for aborted transfers.
REQ-012 Port: rsp_err  output  1  PSLVERR seen or timeout.
REQ-013 Port: rsp_timeout  output  1  transfer aborted by timeout.
REQ-014 Port: PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-015 Port: PADDR, PWDATA  output  32 each  APB address and write data.
REQ-016 Port: PRDATA  input  32; PREADY  input  1; PSLVERR  input  1 (tie to 0 for slaves without it).
REQ-017 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-019 IDLE with cmd_valid: register cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA, go to SETUP.
REQ-020 SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
REQ-021 ACCESS: PSEL=1, PENABLE=1; on PREADY=1 sample PRDATA (reads only) and PSLVERR, go to RESP.
REQ-022 PADDR/PWRITE/PWDATA SHALL hold stable from SETUP through the last ACCESS cycle.
REQ-023 A 16-bit counter SHALL clear on entering ACCESS and increment each ACCESS cycle without PREADY.
REQ-024 With TIMEOUT≠0, when the counter equals TIMEOUT and PREADY=0: go to RESP, set rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-025 PREADY=1 in the cycle the counter reaches TIMEOUT SHALL complete normally (PREADY wins).
REQ-026 RESP: PSEL=0, PENABLE=0, rsp_valid=1; response fields SHALL hold stable until rsp_ready=1, then go to IDLE.
REQ-027 rsp_ready=1 in RESP SHALL return to IDLE that cycle; the next command is accepted no earlier than the following cycle.
REQ-028 Minimum latency: command accepted at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3 with zero-wait slave.
REQ-029 PSEL and PENABLE SHALL be driven from flops (glitch-free); PENABLE SHALL never be 1 while PSEL=0.
REQ-030 cmd_* inputs outside the acceptance cycle SHALL be ignored.

Reset
REQ-031 PRESET=1 SHALL immediately force state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, counter=0.
REQ-032 Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, busy=0, cmd_ready=1 (combinational from IDLE).
REQ-033 Reset mid-transfer SHALL abandon the transfer without producing a response.

Structure
REQ-034 Package ms_apb_pkg SHALL hold the state encoding (IDLE=0, SETUP=1, ACCESS=2, RESP=3) and the default TIMEOUT constant.
REQ-035 Single module; no sub-module, as the counter and FSM are tightly coupled.

Verification
REQ-036 Write 0x0000_0004 ← 0x0000_1234, PREADY=1 -> one SETUP and one ACCESS cycle, rsp_valid at N+3, rsp_err=0.
REQ-037 Read 0x0000_0200, slave inserts 3 wait states, PRDATA=0x0000_002A -> rsp_rdata=0x2A; PADDR stable for all 5 APB cycles.
REQ-038 TIMEOUT=4, PREADY held 0 -> ACCESS lasts 4 cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0, PSEL=0 in RESP.
REQ-039 Read with PSLVERR=1 when PREADY=1 -> rsp_err=1, rsp_timeout=0.
REQ-040 rsp_ready held 0 for 5 cycles -> response stable, cmd_ready=0, no new APB transfer.
REQ-041 PRESET asserted during ACCESS -> PSEL/PENABLE drop without waiting for a clock edge, no rsp_valid; the next command runs normally.
